note_player: RTL and testbench

Consumes the note/duration stream that the song reader emits and turns it into audio samples. Holds one note at a time, advances a phase accumulator on each codec sample strobe, and counts the note's duration in beats. Drives `player_ready` and `note_done` back to the song reader so the next note can be loaded.

---
 rtl/note_player_if.sv | 24 ++
 rtl/note_player.sv | 88 ++++++++
 tb/tb_note_player.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/note_player_if.sv
// Song-reader / codec side bundle for note_player: note load handshake, beat and sample strobes,
// and the sample stream back out.
interface note_player_if;
  logic               play;
  logic [5:0]         note;
  logic [5:0]         duration;
  logic               new_note;
  logic               beat;
  logic               generate_next_sample;
  logic               player_ready;
  logic               note_done;
  logic signed [15:0] sample_out;
  logic               new_sample_ready;

  modport master (
    output play, note, duration, new_note, beat, generate_next_sample,
    input  player_ready, note_done, sample_out, new_sample_ready
  );

  modport slave (
    input  play, note, duration, new_note, beat, generate_next_sample,
    output player_ready, note_done, sample_out, new_sample_ready
  );
endinterface

// File: rtl/note_player.sv
// Square-wave note player: one note at a time, phase accumulator per sample request, beat countdown.
// Define NOTE_PLAYER_GAP_EN to silence the final beat of each note (articulation gap).
module note_player #(
  parameter logic signed [15:0] AMP    = 16'sd8192,
  parameter int                 STEP_W = 20
) (
  input logic           clk,
  input logic           reset,
  note_player_if.slave  bus
);
  // state   | meaning
  // IDLE    | no note held, player_ready high, phase at 0
  // PLAYING | note held, counting beats down to the end of its duration
  typedef enum logic {IDLE, PLAYING} state_t;

  // Phase step per 48 kHz sample for a 2^20 accumulator; index 49 is A4 = 440 Hz.
  localparam int STEP_TAB [64] = '{
        0,   601,   636,   674,   714,   757,   802,   850,   900,   954,  1010,  1070,  1134,
     1201,  1273,  1349,  1429,  1514,  1604,  1699,  1800,  1907,  2021,  2141,  2268,
     2403,  2546,  2697,  2858,  3028,  3208,  3398,  3600,  3815,  4041,  4282,  4536,
     4806,  5092,  5395,  5715,  6055,  6415,  6797,  7201,  7629,  8083,  8563,  9072,
     9612, 10184, 10789, 11431, 12110, 12830, 13593, 14402, 15258, 16165, 17127, 18145,
    19224, 20367, 21578
  };

  state_t            state;
  logic [5:0]        cur_note;
  logic [5:0]        remaining;
  logic [STEP_W-1:0] phase;
  logic [STEP_W-1:0] step;
  logic              active;
  logic              mute;

  assign step             = STEP_W'(STEP_TAB[cur_note]);
  assign active           = (state == PLAYING) && bus.play;
  assign bus.player_ready = (state == IDLE);

`ifdef NOTE_PLAYER_GAP_EN
  assign mute = !active || (cur_note == 6'd0) || (remaining == 6'd1);
`else
  assign mute = !active || (cur_note == 6'd0);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state                <= IDLE;
      cur_note             <= '0;
      remaining            <= '0;
      phase                <= '0;
      bus.note_done        <= 1'b0;
      bus.sample_out       <= '0;
      bus.new_sample_ready <= 1'b0;
    end else begin
      bus.note_done        <= 1'b0;
      bus.new_sample_ready <= bus.generate_next_sample;
      // Sample uses the pre-increment phase so every note starts on the positive half.
      if (bus.generate_next_sample)
        bus.sample_out <= mute ? 16'sd0 : (phase[STEP_W-1] ? -AMP : AMP);
      if (active && bus.generate_next_sample)
        phase <= phase + step;
      unique case (state)
        IDLE: begin
          if (bus.new_note) begin
            cur_note  <= bus.note;
            remaining <= bus.duration;
            phase     <= '0;
            if (bus.duration == 6'd0)
              bus.note_done <= 1'b1;
            else
              state <= PLAYING;
          end
        end
        PLAYING: begin
          if (bus.play && bus.beat) begin
            if (remaining == 6'd1) begin
              remaining     <= '0;
              phase         <= '0;
              state         <= IDLE;
              bus.note_done <= 1'b1;
            end else begin
              remaining <= remaining - 6'd1;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_note_player.sv
// Directed-vector bench for note_player; expected samples come from a local phase model.
module tb_note_player;
  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;
  int   mp;
  int   s;

  note_player_if bus();

  note_player dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef NOTE_PLAYER_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_sample(output int smp);
    bus.generate_next_sample = 1'b1;
    tick();
    smp = int'(bus.sample_out);
    bus.generate_next_sample = 1'b0;
  endtask

  task automatic beat_pulse();
    bus.beat = 1'b1;
    tick();
    bus.beat = 1'b0;
  endtask

  task automatic load(input int n, input int d);
    bus.new_note = 1'b1;
    bus.note     = 6'(n);
    bus.duration = 6'(d);
    tick();
    bus.new_note = 1'b0;
  endtask

  function automatic int sq(input int ph);
    return ((ph & 32'h80000) != 0) ? -8192 : 8192;
  endfunction

  // Take k samples of note 49 and check each against the model phase.
  task automatic run49(input string tag, input int k);
    for (int i = 0; i < k; i++) begin
      req_sample(s);
      chk(tag, s, sq(mp));
      mp = (mp + 9612) % 1048576;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.play = 1'b0;
    bus.note = '0;
    bus.duration = '0;
    bus.new_note = 1'b0;
    bus.beat = 1'b0;
    bus.generate_next_sample = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_ready", int'(bus.player_ready), 1);
    chk("rst_done", int'(bus.note_done), 0);
    chk("rst_sample", int'(bus.sample_out), 0);
    chk("rst_nsr", int'(bus.new_sample_ready), 0);
    chk("rst_phase", int'(dut.phase), 0);

    bus.play = 1'b1;
    req_sample(s);
    chk("idle_nsr", int'(bus.new_sample_ready), 1);
    chk("idle_sample", s, 0);
    tick();
    chk("idle_nsr_pulse", int'(bus.new_sample_ready), 0);
    beat_pulse();
    chk("idle_beat", int'(bus.note_done), 0);

    // note 49, duration 3: 120 samples cover both sign flips and a phase wrap
    load(49, 3);
    chk("load_ready", int'(bus.player_ready), 0);
    chk("load_phase", int'(dut.phase), 0);
    mp = 0;
    run49("sq49", 120);
    chk("phase49", int'(dut.phase), mp);
    beat_pulse();
    chk("b1_done", int'(bus.note_done), 0);
    beat_pulse();
    chk("b2_done", int'(bus.note_done), 0);
    chk("b2_ready", int'(bus.player_ready), 0);
    bus.beat = 1'b1;
    bus.generate_next_sample = 1'b1;
    tick();
    bus.beat = 1'b0;
    bus.generate_next_sample = 1'b0;
    chk("b3_done", int'(bus.note_done), 1);
    chk("b3_ready", int'(bus.player_ready), 1);
    chk("b3_nsr", int'(bus.new_sample_ready), 1);
    chk("b3_sample", int'(bus.sample_out), GAP ? 0 : sq(mp));

    // rest note accepted in the same cycle note_done is high
    load(0, 2);
    chk("done_pulse", int'(bus.note_done), 0);
    chk("rest_ready", int'(bus.player_ready), 0);
    for (int i = 0; i < 4; i++) begin
      req_sample(s);
      chk("rest_sample", s, 0);
    end
    beat_pulse();
    chk("rest_b1", int'(bus.note_done), 0);
    beat_pulse();
    chk("rest_b2", int'(bus.note_done), 1);

    load(5, 0);
    chk("dur0_done", int'(bus.note_done), 1);
    chk("dur0_ready", int'(bus.player_ready), 1);
    tick();
    chk("dur0_done_pulse", int'(bus.note_done), 0);
    chk("dur0_idle", int'(bus.player_ready), 1);

    // pause mid-note for 2 beats
    load(49, 3);
    mp = 0;
    run49("pre_pause", 3);
    beat_pulse();
    bus.play = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_sample(s);
      chk("pause_sample", s, 0);
      beat_pulse();
      chk("pause_done", int'(bus.note_done), 0);
    end
    chk("pause_phase", int'(dut.phase), mp);
    chk("pause_rem", int'(dut.remaining), 2);
    bus.play = 1'b1;
    run49("resume", 3);
    beat_pulse();
    chk("resume_b1", int'(bus.note_done), 0);
    beat_pulse();
    chk("resume_b2", int'(bus.note_done), 1);

    // load while playing is ignored; step must stay 9612
    load(49, 2);
    load(10, 5);
    chk("ign_ready", int'(bus.player_ready), 0);
    mp = 0;
    run49("ign_step", 60);
    chk("ign_phase", int'(dut.phase), mp);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_ready", int'(bus.player_ready), 1);
    chk("mid_rst_done", int'(bus.note_done), 0);
    chk("mid_rst_sample", int'(bus.sample_out), 0);
    chk("mid_rst_phase", int'(dut.phase), 0);
    tick();
    chk("mid_rst_done2", int'(bus.note_done), 0);

    // beat coinciding with a load does not count
    bus.beat = 1'b1;
    load(49, 1);
    bus.beat = 1'b0;
    chk("ldbeat_ready", int'(bus.player_ready), 0);
    beat_pulse();
    chk("ldbeat_done", int'(bus.note_done), 1);

    // articulation gap on the final beat
    load(49, 2);
    mp = 0;
    run49("gap_b1", 3);
    beat_pulse();
    for (int i = 0; i < 3; i++) begin
      req_sample(s);
      chk("gap_b2", s, GAP ? 0 : sq(mp));
      mp = (mp + 9612) % 1048576;
    end
    beat_pulse();
    chk("gap_done", int'(bus.note_done), 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
